mc_run_control: RTL and testbench

Run-control and debug unit for the multi-cycle computer. It gates core progress through a clock-enable and halts the core only at instruction boundaries, that is, when the controller FSM is in its fetch state. Halts come from an external request, completion of an N-instruction single-step, or a match in a bank of NUM_BP PC breakpoints. It also provides free-running cycle and retired-instruction counters. It sits beside the controller/datapath pair inside the computer top level and drives the enable that qualifies PCWrite, IRWrite, MemWrite and RegWrite.

---
 rtl/mc_debug_pkg.sv | 34 +++
 rtl/mc_bp_match.sv | 76 +++++++
 rtl/mc_run_control.sv | 187 ++++++++++++++++++
 tb/tb_mc_run_control.sv | 264 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/mc_debug_pkg.sv
// -----------------------------------------------------------------------------
// mc_debug_pkg
// Shared definitions for the multi-cycle computer's run-control/debug logic:
//   - run_state_t  : run-control FSM states (RUN, STEP, HALTED)
//   - halt_cause_t : encoding reported on halt_cause
//   - clog2        : index-width helper, never returns less than 1 so that a
//                    single-slot breakpoint bank still gets a 1-bit index port
// -----------------------------------------------------------------------------
package mc_debug_pkg;

  typedef enum logic [1:0] {
    ST_RUN    = 2'd0,
    ST_STEP   = 2'd1,
    ST_HALTED = 2'd2
  } run_state_t;

  typedef enum logic [1:0] {
    CAUSE_NONE = 2'b00,
    CAUSE_REQ  = 2'b01,
    CAUSE_BP   = 2'b10,
    CAUSE_STEP = 2'b11
  } halt_cause_t;

  // Ceiling log2 with a floor of 1 bit.
  function automatic int clog2(input int n);
    int w;
    w = 0;
    while ((1 << w) < n) begin
      w = w + 1;
    end
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/mc_bp_match.sv
// -----------------------------------------------------------------------------
// mc_bp_match
// Bank of NUM_BP PC breakpoint slots. Each slot holds an address and an enable.
// The current fetch PC is compared against every enabled slot; the lowest
// matching slot index is reported.
//
// Ports:
//   i_clk      clock, rising edge
//   i_rst_n    asynchronous active-low reset, disables and clears all slots
//   i_we       slot write strobe
//   i_idx      slot written when i_we is high
//   i_addr     breakpoint PC written into the slot
//   i_en       slot enable written together with i_addr
//   i_pc       PC compared against the slots
//   o_hit      some enabled slot matches i_pc
//   o_hit_idx  lowest matching slot index (0 when no hit)
// -----------------------------------------------------------------------------
module mc_bp_match
  import mc_debug_pkg::*;
#(
  parameter int WIDTH  = 32,
  parameter int NUM_BP = 4,
  localparam int IDX_W = clog2(NUM_BP)
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_we,
  input  logic [IDX_W-1:0] i_idx,
  input  logic [WIDTH-1:0] i_addr,
  input  logic             i_en,
  input  logic [WIDTH-1:0] i_pc,
  output logic             o_hit,
  output logic [IDX_W-1:0] o_hit_idx
);

  logic [WIDTH-1:0]  r_addr [NUM_BP];
  logic [NUM_BP-1:0] r_en;
  logic              w_hit;
  logic [IDX_W-1:0]  w_hit_idx;

  // Slot storage. Writes land on the clock edge, so a write and a compare
  // on the same slot in the same cycle still see the old contents. An index
  // beyond NUM_BP-1 (non power-of-two banks) writes nothing.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int i = 0; i < NUM_BP; i++) begin
        r_addr[i] <= '0;
      end
      r_en <= '0;
    end else if (i_we) begin
      for (int i = 0; i < NUM_BP; i++) begin
        if (i_idx == IDX_W'(i)) begin
          r_addr[i] <= i_addr;
          r_en[i]   <= i_en;
        end
      end
    end
  end

  // Comparators and priority encoder. Scanning from the top slot downwards
  // lets the lowest matching index be the last one written.
  always_comb begin
    w_hit     = 1'b0;
    w_hit_idx = '0;
    for (int i = NUM_BP - 1; i >= 0; i--) begin
      if (r_en[i] && (r_addr[i] == i_pc)) begin
        w_hit     = 1'b1;
        w_hit_idx = IDX_W'(i);
      end
    end
  end

  assign o_hit     = w_hit;
  assign o_hit_idx = w_hit_idx;

endmodule

// File: rtl/mc_run_control.sv
// -----------------------------------------------------------------------------
// mc_run_control
// Run-control and debug unit for the multi-cycle computer. Produces the core
// advance enable, halts the core only at instruction boundaries (controller in
// its fetch state) on an external request, on single-step completion or on a
// PC breakpoint, and keeps cycle and retired-instruction counters.
//
// Ports:
//   i_clk           clock, rising edge
//   i_rst_n         asynchronous active-low reset
//   i_fetch_pc      current PC from the datapath
//   i_fsm_fetch     controller is in its fetch state (instruction boundary)
//   i_halt_req      halt request pulse
//   i_run_req       resume free-running (only acted on while halted)
//   i_step_req      run i_step_count instructions then halt (while halted)
//   i_step_count    step length, 0 behaves as 1
//   i_bp_we         breakpoint slot write strobe
//   i_bp_idx        breakpoint slot written
//   i_bp_addr       breakpoint PC
//   i_bp_en         slot enable written with i_bp_addr
//   o_core_en       core advance enable (combinational on fetch_pc/fsm_fetch)
//   o_halted        core is held
//   o_halt_cause    00 none, 01 request, 10 breakpoint, 11 step done
//   o_bp_hit_idx    slot that caused the last breakpoint halt
//   o_cycle_count   cycles with core_en high
//   o_instr_count   instructions started (fsm_fetch && core_en)
// -----------------------------------------------------------------------------
module mc_run_control
  import mc_debug_pkg::*;
#(
  parameter int WIDTH         = 32,
  parameter int NUM_BP        = 4,
  parameter int CNT_WIDTH     = 32,
  parameter int STEP_W        = 8,
  parameter bit START_RUNNING = 1'b1,
  localparam int IDX_W        = clog2(NUM_BP)
) (
  input  logic                 i_clk,
  input  logic                 i_rst_n,
  input  logic [WIDTH-1:0]     i_fetch_pc,
  input  logic                 i_fsm_fetch,
  input  logic                 i_halt_req,
  input  logic                 i_run_req,
  input  logic                 i_step_req,
  input  logic [STEP_W-1:0]    i_step_count,
  input  logic                 i_bp_we,
  input  logic [IDX_W-1:0]     i_bp_idx,
  input  logic [WIDTH-1:0]     i_bp_addr,
  input  logic                 i_bp_en,
  output logic                 o_core_en,
  output logic                 o_halted,
  output logic [1:0]           o_halt_cause,
  output logic [IDX_W-1:0]     o_bp_hit_idx,
  output logic [CNT_WIDTH-1:0] o_cycle_count,
  output logic [CNT_WIDTH-1:0] o_instr_count
);

  run_state_t           r_state;
  logic                 r_pending;
  logic                 r_skip;
  logic [STEP_W-1:0]    r_remaining;
  halt_cause_t          r_halt_cause;
  logic [IDX_W-1:0]     r_bp_hit_idx;
  logic [CNT_WIDTH-1:0] r_cycle_count;
  logic [CNT_WIDTH-1:0] r_instr_count;

  logic                 w_hit;
  logic [IDX_W-1:0]     w_hit_idx;
  logic                 w_active;
  logic                 w_boundary;
  logic                 w_bp_live;
  logic                 w_step_done;
  logic                 w_stop;
  logic                 w_core_en;

  mc_bp_match #(
    .WIDTH  (WIDTH),
    .NUM_BP (NUM_BP)
  ) u_bp_match (
    .i_clk     (i_clk),
    .i_rst_n   (i_rst_n),
    .i_we      (i_bp_we),
    .i_idx     (i_bp_idx),
    .i_addr    (i_bp_addr),
    .i_en      (i_bp_en),
    .i_pc      (i_fetch_pc),
    .o_hit     (w_hit),
    .o_hit_idx (w_hit_idx)
  );

  // Stop condition, only evaluated at a boundary while the core is running.
  // A breakpoint is masked by the skip flag so that resuming from a
  // breakpoint PC does not immediately halt again on the same fetch.
  assign w_active    = (r_state != ST_HALTED);
  assign w_boundary  = w_active && i_fsm_fetch;
  assign w_bp_live   = w_hit && !r_skip;
  assign w_step_done = (r_state == ST_STEP) && (r_remaining == '0);
  assign w_stop      = w_boundary && (r_pending || w_bp_live || w_step_done);
  assign w_core_en   = w_active && !w_stop;

  // Run-control FSM. While running, the first stop source in priority order
  // (pending request, breakpoint, step exhausted) sets the cause; a stop
  // clears the pending flag even if a new halt request arrives that same
  // cycle, since the core is halting anyway. In HALTED a halt request blocks
  // any resume command, and step beats run. Leaving HALTED clears the cause
  // and arms the skip flag for one boundary.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state      <= START_RUNNING ? ST_RUN : ST_HALTED;
      r_pending    <= 1'b0;
      r_skip       <= 1'b0;
      r_remaining  <= '0;
      r_halt_cause <= CAUSE_NONE;
      r_bp_hit_idx <= '0;
    end else begin
      case (r_state)
        ST_RUN, ST_STEP: begin
          if (w_stop) begin
            r_state   <= ST_HALTED;
            r_pending <= 1'b0;
            r_skip    <= 1'b0;
            if (r_pending) begin
              r_halt_cause <= CAUSE_REQ;
            end else if (w_bp_live) begin
              r_halt_cause <= CAUSE_BP;
              r_bp_hit_idx <= w_hit_idx;
            end else begin
              r_halt_cause <= CAUSE_STEP;
            end
          end else begin
            if (i_halt_req) begin
              r_pending <= 1'b1;
            end
            if (w_boundary) begin
              r_skip <= 1'b0;
              if (r_state == ST_STEP) begin
                r_remaining <= r_remaining - STEP_W'(1);
              end
            end
          end
        end
        ST_HALTED: begin
          if (i_halt_req) begin
            r_state <= ST_HALTED;
          end else if (i_step_req) begin
            r_state      <= ST_STEP;
            r_remaining  <= (i_step_count == '0) ? STEP_W'(1) : i_step_count;
            r_skip       <= 1'b1;
            r_halt_cause <= CAUSE_NONE;
            r_bp_hit_idx <= '0;
          end else if (i_run_req) begin
            r_state      <= ST_RUN;
            r_skip       <= 1'b1;
            r_halt_cause <= CAUSE_NONE;
            r_bp_hit_idx <= '0;
          end
        end
        default: begin
          r_state <= ST_HALTED;
        end
      endcase
    end
  end

  // Free-running counters, wrapping naturally at 2^CNT_WIDTH.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_cycle_count <= '0;
      r_instr_count <= '0;
    end else begin
      if (w_core_en) begin
        r_cycle_count <= r_cycle_count + CNT_WIDTH'(1);
      end
      if (w_core_en && i_fsm_fetch) begin
        r_instr_count <= r_instr_count + CNT_WIDTH'(1);
      end
    end
  end

  assign o_core_en     = w_core_en;
  assign o_halted      = (r_state == ST_HALTED);
  assign o_halt_cause  = r_halt_cause;
  assign o_bp_hit_idx  = r_bp_hit_idx;
  assign o_cycle_count = r_cycle_count;
  assign o_instr_count = r_instr_count;

endmodule

// File: tb/tb_mc_run_control.sv
// -----------------------------------------------------------------------------
// tb_mc_run_control
// Directed, table-driven bench for mc_run_control with default parameters
// (START_RUNNING=1, NUM_BP=4). Each table row is one clock cycle of inputs
// plus the hand-derived core_en/halted/halt_cause/bp_hit_idx for that cycle.
// Expected counters are accumulated from the expected core_en column.
// -----------------------------------------------------------------------------
module tb_mc_run_control;
  import mc_debug_pkg::*;

  logic        clk;
  logic        rstN;
  logic [31:0] fetchPc;
  logic        fsmFetch;
  logic        haltReq;
  logic        runReq;
  logic        stepReq;
  logic [7:0]  stepCount;
  logic        bpWe;
  logic [1:0]  bpIdx;
  logic [31:0] bpAddr;
  logic        bpEn;
  logic        coreEn;
  logic        halted;
  logic [1:0]  haltCause;
  logic [1:0]  bpHitIdx;
  logic [31:0] cycleCount;
  logic [31:0] instrCount;

  int checks;
  int errors;
  int expCycle;
  int expInstr;

  typedef struct {
    logic        halt;
    logic        run;
    logic        stp;
    logic [7:0]  cnt;
    logic        fetch;
    logic [31:0] pc;
    logic        we;
    logic [1:0]  idx;
    logic [31:0] addr;
    logic        en;
    logic        eCore;
    logic        eHalt;
    logic [1:0]  eCause;
    logic [1:0]  eIdx;
  } vec_t;

  vec_t vecs[$];

  mc_run_control #(
    .WIDTH         (32),
    .NUM_BP        (4),
    .CNT_WIDTH     (32),
    .STEP_W        (8),
    .START_RUNNING (1'b1)
  ) dut (
    .i_clk         (clk),
    .i_rst_n       (rstN),
    .i_fetch_pc    (fetchPc),
    .i_fsm_fetch   (fsmFetch),
    .i_halt_req    (haltReq),
    .i_run_req     (runReq),
    .i_step_req    (stepReq),
    .i_step_count  (stepCount),
    .i_bp_we       (bpWe),
    .i_bp_idx      (bpIdx),
    .i_bp_addr     (bpAddr),
    .i_bp_en       (bpEn),
    .o_core_en     (coreEn),
    .o_halted      (halted),
    .o_halt_cause  (haltCause),
    .o_bp_hit_idx  (bpHitIdx),
    .o_cycle_count (cycleCount),
    .o_instr_count (instrCount)
  );

  // 10 ns clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Build one table row
  function automatic vec_t mk(input logic h, input logic r, input logic s,
                              input logic [7:0] c, input logic f,
                              input logic [31:0] p, input logic w,
                              input logic [1:0] i, input logic [31:0] a,
                              input logic e, input logic ec, input logic eh,
                              input logic [1:0] eca, input logic [1:0] ei);
    vec_t v;
    v = '{h, r, s, c, f, p, w, i, a, e, ec, eh, eca, ei};
    return v;
  endfunction

  // One comparison
  task automatic checkOutput(input string name, input int tag,
                             input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("[TB] FAIL vec %0d %s got %0h want %0h", tag, name, got, want);
    end
  endtask

  // Drive one cycle of inputs, sample between edges, advance to next negedge
  task automatic applyStimulus(input vec_t v, input int tag);
    haltReq   = v.halt;
    runReq    = v.run;
    stepReq   = v.stp;
    stepCount = v.cnt;
    fsmFetch  = v.fetch;
    fetchPc   = v.pc;
    bpWe      = v.we;
    bpIdx     = v.idx;
    bpAddr    = v.addr;
    bpEn      = v.en;
    #1;
    checkOutput("core_en", tag, {31'd0, coreEn}, {31'd0, v.eCore});
    checkOutput("halted", tag, {31'd0, halted}, {31'd0, v.eHalt});
    checkOutput("halt_cause", tag, {30'd0, haltCause}, {30'd0, v.eCause});
    checkOutput("bp_hit_idx", tag, {30'd0, bpHitIdx}, {30'd0, v.eIdx});
    checkOutput("cycle_count", tag, cycleCount, expCycle);
    checkOutput("instr_count", tag, instrCount, expInstr);
    if (v.eCore) begin
      expCycle++;
      if (v.fetch) expInstr++;
    end
    @(negedge clk);
  endtask

  initial begin
    checks   = 0;
    errors   = 0;
    expCycle = 0;
    expInstr = 0;
    rstN      = 1'b0;
    haltReq   = 1'b0;
    runReq    = 1'b0;
    stepReq   = 1'b0;
    stepCount = 8'd0;
    fsmFetch  = 1'b0;
    fetchPc   = 32'd0;
    bpWe      = 1'b0;
    bpIdx     = 2'd0;
    bpAddr    = 32'd0;
    bpEn      = 1'b0;

    // Free run, fetch every 4th cycle (0..9)
    for (int c = 0; c < 10; c++)
      vecs.push_back(mk(0,0,0,0, (c % 4) == 0, 32'h100 + c, 0,0,0,0, 1,0,0,0));
    // Halt request, boundary three cycles later (10..17)
    vecs.push_back(mk(0,0,0,0, 0,32'h10a, 0,0,0,0, 1,0,0,0));
    vecs.push_back(mk(0,0,0,0, 0,32'h10b, 0,0,0,0, 1,0,0,0));
    vecs.push_back(mk(0,0,0,0, 1,32'h10c, 0,0,0,0, 1,0,0,0));
    vecs.push_back(mk(1,0,0,0, 0,32'h10c, 0,0,0,0, 1,0,0,0));
    vecs.push_back(mk(0,0,0,0, 0,32'h10c, 0,0,0,0, 1,0,0,0));
    vecs.push_back(mk(0,0,0,0, 0,32'h10c, 0,0,0,0, 1,0,0,0));
    vecs.push_back(mk(0,0,0,0, 1,32'h200, 0,0,0,0, 0,0,0,0));
    vecs.push_back(mk(0,0,0,0, 1,32'h200, 0,0,0,0, 0,1,1,0));
    // halt+run while halted stays halted (18..19)
    vecs.push_back(mk(1,1,0,0, 1,32'h200, 0,0,0,0, 0,1,1,0));
    vecs.push_back(mk(0,0,0,0, 1,32'h200, 0,0,0,0, 0,1,1,0));
    // Step 3, run_req ignored mid-step (20..27)
    vecs.push_back(mk(0,0,1,3, 1,32'h300, 0,0,0,0, 0,1,1,0));
    vecs.push_back(mk(0,0,0,0, 1,32'h300, 0,0,0,0, 1,0,0,0));
    vecs.push_back(mk(0,1,0,0, 0,32'h300, 0,0,0,0, 1,0,0,0));
    vecs.push_back(mk(0,0,0,0, 1,32'h304, 0,0,0,0, 1,0,0,0));
    vecs.push_back(mk(0,0,0,0, 1,32'h308, 0,0,0,0, 1,0,0,0));
    vecs.push_back(mk(0,0,0,0, 0,32'h308, 0,0,0,0, 1,0,0,0));
    vecs.push_back(mk(0,0,0,0, 1,32'h30c, 0,0,0,0, 0,0,0,0));
    vecs.push_back(mk(0,0,0,0, 1,32'h30c, 0,0,0,0, 0,1,3,0));
    // Step 0 behaves as 1 (28..31)
    vecs.push_back(mk(0,0,1,0, 1,32'h30c, 0,0,0,0, 0,1,3,0));
    vecs.push_back(mk(0,0,0,0, 1,32'h30c, 0,0,0,0, 1,0,0,0));
    vecs.push_back(mk(0,0,0,0, 0,32'h30c, 0,0,0,0, 1,0,0,0));
    vecs.push_back(mk(0,0,0,0, 1,32'h310, 0,0,0,0, 0,0,0,0));
    // Program slots 1,2 = 0x40, slot 3 = 0x40 disabled (32..34)
    vecs.push_back(mk(0,0,0,0, 1,32'h310, 1,1,32'h40,1, 0,1,3,0));
    vecs.push_back(mk(0,0,0,0, 1,32'h310, 1,2,32'h40,1, 0,1,3,0));
    vecs.push_back(mk(0,0,0,0, 1,32'h310, 1,3,32'h40,0, 0,1,3,0));
    // Run to breakpoint at 0x40 (35..39)
    vecs.push_back(mk(0,1,0,0, 1,32'h010, 0,0,0,0, 0,1,3,0));
    vecs.push_back(mk(0,0,0,0, 1,32'h010, 0,0,0,0, 1,0,0,0));
    vecs.push_back(mk(0,0,0,0, 0,32'h010, 0,0,0,0, 1,0,0,0));
    vecs.push_back(mk(0,0,0,0, 1,32'h040, 0,0,0,0, 0,0,0,0));
    vecs.push_back(mk(0,0,0,0, 1,32'h040, 0,0,0,0, 0,1,2,1));
    // Resume past 0x40, next arrival halts again (40..46)
    vecs.push_back(mk(0,1,0,0, 1,32'h040, 0,0,0,0, 0,1,2,1));
    vecs.push_back(mk(0,0,0,0, 1,32'h040, 0,0,0,0, 1,0,0,0));
    vecs.push_back(mk(0,0,0,0, 0,32'h040, 0,0,0,0, 1,0,0,0));
    vecs.push_back(mk(0,0,0,0, 1,32'h044, 0,0,0,0, 1,0,0,0));
    vecs.push_back(mk(0,0,0,0, 0,32'h044, 0,0,0,0, 1,0,0,0));
    vecs.push_back(mk(0,0,0,0, 1,32'h040, 0,0,0,0, 0,0,0,0));
    vecs.push_back(mk(0,0,0,0, 1,32'h040, 0,0,0,0, 0,1,2,1));
    // Pending halt and breakpoint on the same boundary -> request (47..51)
    vecs.push_back(mk(0,1,0,0, 1,32'h040, 0,0,0,0, 0,1,2,1));
    vecs.push_back(mk(0,0,0,0, 1,32'h040, 0,0,0,0, 1,0,0,0));
    vecs.push_back(mk(1,0,0,0, 0,32'h040, 0,0,0,0, 1,0,0,0));
    vecs.push_back(mk(0,0,0,0, 1,32'h040, 0,0,0,0, 0,0,0,0));
    vecs.push_back(mk(0,0,0,0, 1,32'h040, 0,0,0,0, 0,1,1,0));
    // Slot write and match in the same cycle use the old slot (52..57)
    vecs.push_back(mk(0,1,0,0, 1,32'h040, 0,0,0,0, 0,1,1,0));
    vecs.push_back(mk(0,0,0,0, 1,32'h040, 0,0,0,0, 1,0,0,0));
    vecs.push_back(mk(0,0,0,0, 1,32'h050, 1,0,32'h50,1, 1,0,0,0));
    vecs.push_back(mk(0,0,0,0, 0,32'h050, 0,0,0,0, 1,0,0,0));
    vecs.push_back(mk(0,0,0,0, 1,32'h050, 0,0,0,0, 0,0,0,0));
    vecs.push_back(mk(0,0,0,0, 1,32'h050, 0,0,0,0, 0,1,2,0));
    // step beats run (58..62)
    vecs.push_back(mk(0,1,1,2, 1,32'h050, 0,0,0,0, 0,1,2,0));
    vecs.push_back(mk(0,0,0,0, 1,32'h050, 0,0,0,0, 1,0,0,0));
    vecs.push_back(mk(0,0,0,0, 1,32'h060, 0,0,0,0, 1,0,0,0));
    vecs.push_back(mk(0,0,0,0, 1,32'h064, 0,0,0,0, 0,0,0,0));
    vecs.push_back(mk(0,0,0,0, 1,32'h064, 0,0,0,0, 0,1,3,0));
    // Enter a 5-step with a halt pending (63..64)
    vecs.push_back(mk(0,0,1,5, 1,32'h064, 0,0,0,0, 0,1,3,0));
    vecs.push_back(mk(1,0,0,0, 0,32'h064, 0,0,0,0, 1,0,0,0));

    // Reset state
    @(negedge clk);
    @(negedge clk);
    #1;
    checkOutput("rst core_en", -1, {31'd0, coreEn}, 32'd1);
    checkOutput("rst halted", -1, {31'd0, halted}, 32'd0);
    checkOutput("rst halt_cause", -1, {30'd0, haltCause}, 32'd0);
    checkOutput("rst cycle_count", -1, cycleCount, 32'd0);
    checkOutput("rst instr_count", -1, instrCount, 32'd0);
    @(negedge clk);
    rstN = 1'b1;

    for (int i = 0; i < vecs.size(); i++) begin
      applyStimulus(vecs[i], i);
    end

    // Asynchronous reset mid-step with a halt pending
    haltReq  = 1'b0;
    fsmFetch = 1'b0;
    #2;
    rstN = 1'b0;
    #1;
    checkOutput("midrst halted", 100, {31'd0, halted}, 32'd0);
    checkOutput("midrst core_en", 100, {31'd0, coreEn}, 32'd1);
    checkOutput("midrst halt_cause", 100, {30'd0, haltCause}, 32'd0);
    checkOutput("midrst cycle_count", 100, cycleCount, 32'd0);
    checkOutput("midrst instr_count", 100, instrCount, 32'd0);
    @(negedge clk);
    rstN     = 1'b1;
    expCycle = 0;
    expInstr = 0;
    // Old slots, pending halt and step budget must all be gone
    applyStimulus(mk(0,0,0,0, 1,32'h040, 0,0,0,0, 1,0,0,0), 101);
    applyStimulus(mk(0,0,0,0, 1,32'h050, 0,0,0,0, 1,0,0,0), 102);
    for (int i = 0; i < 4; i++)
      applyStimulus(mk(0,0,0,0, 1,32'h400 + 4*i, 0,0,0,0, 1,0,0,0), 103 + i);
    #1;
    checkOutput("final cycle_count", 110, cycleCount, 32'd6);
    checkOutput("final instr_count", 110, instrCount, 32'd6);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
